// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - samples stopwatch ms/s, converts to BCD, drives six 7-segment digits
//
// Purpose: every REFRESH_DIV cycles latch (and clamp) the ms and s values,
// convert them serially with shift-add-3, then update all digits in one edge.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   ms    - binary milliseconds, 0..999 (larger values clamp to 999)
//   s     - binary seconds, 0..99 (larger values clamp to 99)
//   hex0  - ms units digit, active-low segments g..a
//   hex1  - ms tens digit
//   hex2  - ms hundreds digit
//   hex3  - s units digit
//   hex4  - s tens digit
//   hex5  - unused digit, always blank
//   busy  - high from the latch edge until the display update edge

module stopwatch_display #(
    parameter int REFRESH_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ms,
    input  logic [6:0] s,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       busy
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_MS = 2'd1,
        CONV_S  = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    ms_sh_q, ms_sh_d;
    logic [6:0]    s_sh_q, s_sh_d;
    logic [11:0]   bcd_ms_q, bcd_ms_d;
    logic [7:0]    bcd_s_q, bcd_s_d;
    logic [6:0]    hex0_q, hex0_d;
    logic [6:0]    hex1_q, hex1_d;
    logic [6:0]    hex2_q, hex2_d;
    logic [6:0]    hex3_q, hex3_d;
    logic [6:0]    hex4_q, hex4_d;
    logic          busy_q, busy_d;
    logic          tick;
    logic [11:0]   adj_ms;
    logic [11:0]   adj_s;

    // Add 3 to every BCD nibble that is 5 or more, so the following
    // shift carries correctly into the next decimal digit.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    assign tick   = (cnt_q == CW'(REFRESH_DIV - 1));
    assign adj_ms = add3(bcd_ms_q);
    assign adj_s  = add3({4'd0, bcd_s_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            ms_sh_q  <= '0;
            s_sh_q   <= '0;
            bcd_ms_q <= '0;
            bcd_s_q  <= '0;
            hex0_q   <= SEG_ZERO;
            hex1_q   <= SEG_ZERO;
            hex2_q   <= SEG_ZERO;
            hex3_q   <= SEG_ZERO;
            hex4_q   <= SEG_ZERO;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            ms_sh_q  <= ms_sh_d;
            s_sh_q   <= s_sh_d;
            bcd_ms_q <= bcd_ms_d;
            bcd_s_q  <= bcd_s_d;
            hex0_q   <= hex0_d;
            hex1_q   <= hex1_d;
            hex2_q   <= hex2_d;
            hex3_q   <= hex3_d;
            hex4_q   <= hex4_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        bit_d    = bit_q;
        ms_sh_d  = ms_sh_q;
        s_sh_d   = s_sh_q;
        bcd_ms_d = bcd_ms_q;
        bcd_s_d  = bcd_s_q;
        hex0_d   = hex0_q;
        hex1_d   = hex1_q;
        hex2_d   = hex2_q;
        hex3_d   = hex3_q;
        hex4_d   = hex4_q;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    ms_sh_d  = (ms > 10'd999) ? 10'd999 : ms;
                    s_sh_d   = (s > 7'd99) ? 7'd99 : s;
                    bcd_ms_d = '0;
                    bcd_s_d  = '0;
                    bit_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CONV_MS;
                end
            end
            CONV_MS: begin
                bcd_ms_d = {adj_ms[10:0], ms_sh_q[9]};
                ms_sh_d  = {ms_sh_q[8:0], 1'b0};
                if (bit_q == 4'd9) begin
                    bit_d   = '0;
                    state_d = CONV_S;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            CONV_S: begin
                bcd_s_d = {adj_s[6:0], s_sh_q[6]};
                s_sh_d  = {s_sh_q[5:0], 1'b0};
                if (bit_q == 4'd6) begin
                    bit_d   = '0;
                    state_d = UPDATE;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            UPDATE: begin
                // All five digits load on this single edge so the display never tears.
                hex0_d  = seg7(bcd_ms_q[3:0]);
                hex1_d  = seg7(bcd_ms_q[7:4]);
                hex2_d  = seg7(bcd_ms_q[11:8]);
                hex3_d  = seg7(bcd_s_q[3:0]);
                hex4_d  = seg7(bcd_s_q[7:4]);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hex0 = hex0_q;
    assign hex1 = hex1_q;
    assign hex2 = hex2_q;
    assign hex3 = hex3_q;
    assign hex4 = hex4_q;
    assign hex5 = SEG_BLANK;
    assign busy = busy_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - self-checking bench for stopwatch_display

module tb_stopwatch_display;

    localparam int DIV = 20;

    logic       clk;
    logic       rst;
    logic [9:0] ms;
    logic [6:0] s;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    stopwatch_display #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .ms   (ms),
        .s    (s),
        .hex0 (hex0),
        .hex1 (hex1),
        .hex2 (hex2),
        .hex3 (hex3),
        .hex4 (hex4),
        .hex5 (hex5),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a sample is taken when the free-running count hits DIV-1,
    // and the decimal digits of the clamped values appear 18 edges later.
    int cnt_m = 0;
    int rem_m = 0;
    int lat_ms = 0, lat_s = 0;
    int d_ms = 0, d_s = 0;

    always @(posedge clk) begin
        if (!rst) begin
            cnt_m = 0;
            rem_m = 0;
            d_ms  = 0;
            d_s   = 0;
        end else begin
            if (rem_m > 0) begin
                rem_m--;
                if (rem_m == 0) begin
                    d_ms = lat_ms;
                    d_s  = lat_s;
                end
            end else if (cnt_m == DIV - 1) begin
                lat_ms = (int'(ms) > 999) ? 999 : int'(ms);
                lat_s  = (int'(s) > 99) ? 99 : int'(s);
                rem_m  = 18;
            end
            cnt_m = (cnt_m + 1) % DIV;
        end
    end

    always @(negedge clk) begin
        int e_ms, e_s, e_busy;
        e_ms   = rst ? d_ms : 0;
        e_s    = rst ? d_s : 0;
        e_busy = (rst && rem_m > 0) ? 1 : 0;
        check("m_hex0", hex0, seg[e_ms % 10]);
        check("m_hex1", hex1, seg[(e_ms / 10) % 10]);
        check("m_hex2", hex2, seg[e_ms / 100]);
        check("m_hex3", hex3, seg[e_s % 10]);
        check("m_hex4", hex4, seg[e_s / 10]);
        check("m_hex5", hex5, 7'b1111111);
        check("m_busy", busy, e_busy);
    end

    task automatic wait_busy(input logic lvl);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) check("wait_busy_timeout", busy, lvl);
    endtask

    task automatic check_digits(input string name, input logic [6:0] h4, input logic [6:0] h3,
                                input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
        check({name, "_hex4"}, hex4, h4);
        check({name, "_hex3"}, hex3, h3);
        check({name, "_hex2"}, hex2, h2);
        check({name, "_hex1"}, hex1, h1);
        check({name, "_hex0"}, hex0, h0);
    endtask

    initial begin
        int n;
        logic seen, done;

        rst = 1'b0;
        ms  = 10'd0;
        s   = 7'd0;
        repeat (3) @(negedge clk);
        check_digits("reset", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
        check("reset_hex5", hex5, 7'b1111111);
        check("reset_busy", busy, 0);

        @(posedge clk);
        #1 rst = 1'b1;
        wait_busy(1'b1);
        wait_busy(1'b0);
        check_digits("first_zero", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

        ms = 10'd123;
        s  = 7'd45;
        wait_busy(1'b1);
        wait_busy(1'b0);
        check_digits("map_123_45", 7'b0011001, 7'b0010010, 7'b1111001, 7'b0100100, 7'b0110000);

        ms = 10'd999;
        s  = 7'd99;
        wait_busy(1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, 18);
        check_digits("max_999_99", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

        ms = 10'd1000;
        s  = 7'd127;
        wait_busy(1'b1);
        wait_busy(1'b0);
        check_digits("clamp", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

        ms = 10'd500;
        s  = 7'd0;
        wait_busy(1'b1);
        @(posedge clk);
        #1 ms = 10'd7;
        wait_busy(1'b0);
        check_digits("stable_500", 7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000);
        wait_busy(1'b1);
        wait_busy(1'b0);
        check_digits("next_007", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000);

        ms = 10'd321;
        s  = 7'd12;
        wait_busy(1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check_digits("abort", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        n    = 0;
        seen = 1'b0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check("release_latency", n, DIV + 18);
        check_digits("after_release", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0100100, 7'b1111001);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
